// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, payload struct and helpers for the common data bus (CDB) arbiter.
// The RS (reservation station) bus widths live here too, so every block that
// imports this package uses the same sizes.
package cdb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned NAME_W   = 5;
  localparam int unsigned RS_OPC_W = 6;
  localparam int unsigned RS_IMM_W = 16;
  localparam int unsigned NUM_SRC  = 3;

  localparam logic [TAG_W-1:0] TAG_FREE = '0;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LS  = 2'd1,
    SRC_BR  = 2'd2
  } src_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [NAME_W-1:0] name;
  } cdb_entry_t;

  localparam cdb_entry_t CDB_IDLE = '{tag: TAG_FREE, data: '0, name: '0};

  // (base + off) mod 3; both operands are expected to be below 3.
  function automatic logic [1:0] src_wrap(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result sources (alu/ls/br) and the two broadcast ports (O, T) of the CDB arbiter.
// master: producers/consumers around the arbiter; slave: the arbiter itself.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic              flush;
  logic              busy;

  logic              alu_valid, ls_valid, br_valid;
  logic [TAG_W-1:0]  alu_tag, ls_tag, br_tag;
  logic [DATA_W-1:0] alu_data, ls_data, br_data;
  logic [NAME_W-1:0] alu_name, ls_name, br_name;
  logic              alu_ready, ls_ready, br_ready;

  logic              enWrtO, enWrtT;
  logic [TAG_W-1:0]  WrtTagO, WrtTagT;
  logic [DATA_W-1:0] WrtDataO, WrtDataT;
  logic [NAME_W-1:0] WrtNameO, WrtNameT;

  modport master (
    output flush,
    output alu_valid, alu_tag, alu_data, alu_name,
    output ls_valid, ls_tag, ls_data, ls_name,
    output br_valid, br_tag, br_data, br_name,
    input  alu_ready, ls_ready, br_ready,
    input  enWrtO, WrtTagO, WrtDataO, WrtNameO,
    input  enWrtT, WrtTagT, WrtDataT, WrtNameT,
    input  busy
  );

  modport slave (
    input  flush,
    input  alu_valid, alu_tag, alu_data, alu_name,
    input  ls_valid, ls_tag, ls_data, ls_name,
    input  br_valid, br_tag, br_data, br_name,
    output alu_ready, ls_ready, br_ready,
    output enWrtO, WrtTagO, WrtDataO, WrtNameO,
    output enWrtT, WrtTagT, WrtDataT, WrtNameT,
    output busy
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result queue: DEPTH entries of {tag, data, name} with occupancy count.
// Ports: clk, rst (async active-low), flush (clears, beats push/pop), push/push_entry,
//        pop (caller guarantees non-empty), head (oldest entry), count (0..DEPTH).
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  cdb_entry_t       push_entry,
  input  logic             pop,
  output cdb_entry_t       head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers, count and storage; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues results from alu/ls/br and broadcasts up to two
// per cycle on ports O and T, round-robin starting at rr_ptr.
// Ports: clk, rst (async active-low), bus (cdb_arbiter_if.slave: flush, per-source
//        valid/tag/data/name/ready, enWrt/WrtTag/WrtData/WrtName for O and T, busy).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [NUM_SRC-1:0] src_valid, src_ready, push, pop, nonempty;
  cdb_entry_t         src_entry [NUM_SRC];
  cdb_entry_t         head      [NUM_SRC];
  logic [CNT_W-1:0]   count     [NUM_SRC];

  logic               gnt_o_vld, gnt_t_vld;
  logic [1:0]         gnt_o_src, gnt_t_src, probe;

  logic               en_o_q, en_o_d, en_t_q, en_t_d;
  cdb_entry_t         bc_o_q, bc_o_d, bc_t_q, bc_t_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;

  assign src_valid    = {bus.br_valid, bus.ls_valid, bus.alu_valid};
  assign src_entry[0] = '{tag: bus.alu_tag, data: bus.alu_data, name: bus.alu_name};
  assign src_entry[1] = '{tag: bus.ls_tag,  data: bus.ls_data,  name: bus.ls_name};
  assign src_entry[2] = '{tag: bus.br_tag,  data: bus.br_data,  name: bus.br_name};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Ready comes from the registered count only.
    assign src_ready[i] = (count[i] < CNT_W'(DEPTH));
    assign nonempty[i]  = (count[i] != '0);
    assign push[i]      = src_valid[i] & src_ready[i];

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.flush),
      .push       (push[i]),
      .push_entry (src_entry[i]),
      .pop        (pop[i]),
      .head       (head[i]),
      .count      (count[i])
    );
  end

  assign bus.alu_ready = src_ready[0];
  assign bus.ls_ready  = src_ready[1];
  assign bus.br_ready  = src_ready[2];

  // Round-robin search from rr_ptr: first non-empty source -> O, second -> T.
  always_comb begin
    gnt_o_vld = 1'b0;
    gnt_t_vld = 1'b0;
    gnt_o_src = rr_ptr_q;
    gnt_t_src = rr_ptr_q;
    probe     = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      probe = src_wrap(rr_ptr_q, 2'(k));
      if (nonempty[probe]) begin
        if (!gnt_o_vld) begin
          gnt_o_vld = 1'b1;
          gnt_o_src = probe;
        end else if (!gnt_t_vld) begin
          gnt_t_vld = 1'b1;
          gnt_t_src = probe;
        end
      end
    end
  end

  // Granted heads are popped at the same edge that registers them for broadcast.
  always_comb begin
    pop = '0;
    if (!bus.flush) begin
      if (gnt_o_vld) pop[gnt_o_src] = 1'b1;
      if (gnt_t_vld) pop[gnt_t_src] = 1'b1;
    end
  end

  // Broadcast registers and rr_ptr; flush idles both ports but keeps rr_ptr.
  always_comb begin
    en_o_d   = 1'b0;
    en_t_d   = 1'b0;
    bc_o_d   = CDB_IDLE;
    bc_t_d   = CDB_IDLE;
    rr_ptr_d = rr_ptr_q;
    if (!bus.flush) begin
      if (gnt_o_vld) begin
        en_o_d   = 1'b1;
        bc_o_d   = head[gnt_o_src];
        rr_ptr_d = src_wrap(gnt_o_src, 2'd1);
      end
      if (gnt_t_vld) begin
        en_t_d   = 1'b1;
        bc_t_d   = head[gnt_t_src];
        rr_ptr_d = src_wrap(gnt_t_src, 2'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_o_q   <= 1'b0;
      en_t_q   <= 1'b0;
      bc_o_q   <= CDB_IDLE;
      bc_t_q   <= CDB_IDLE;
      rr_ptr_q <= 2'd0;
    end else begin
      en_o_q   <= en_o_d;
      en_t_q   <= en_t_d;
      bc_o_q   <= bc_o_d;
      bc_t_q   <= bc_t_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.enWrtO   = en_o_q;
  assign bus.WrtTagO  = bc_o_q.tag;
  assign bus.WrtDataO = bc_o_q.data;
  assign bus.WrtNameO = bc_o_q.name;
  assign bus.enWrtT   = en_t_q;
  assign bus.WrtTagT  = bc_t_q.tag;
  assign bus.WrtDataT = bc_t_q.data;
  assign bus.WrtNameT = bc_t_q.name;

  assign bus.busy = (|nonempty) | en_o_q | en_t_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random stimulus for cdb_arbiter with a per-source scoreboard.
// Result data carries its source in bits [31:30] so broadcasts can be matched.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic rst;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  cdb_entry_t  sb [3][$];
  cdb_entry_t  cur [3];
  logic [2:0]  offer, acc, had, got;
  logic        flush_v;
  int          wait_cnt [3];
  logic [15:0] seq;
  logic        saw_ls_full;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cdb_entry_t mk(input int s, input logic [15:0] n,
                                    input logic [4:0] tg, input logic [4:0] nm);
    cdb_entry_t e;
    e.tag  = tg;
    e.data = {2'(s), 14'd0, n};
    e.name = nm;
    return e;
  endfunction

  function automatic cdb_entry_t obs_o();
    return '{tag: bus.WrtTagO, data: bus.WrtDataO, name: bus.WrtNameO};
  endfunction

  function automatic cdb_entry_t obs_t();
    return '{tag: bus.WrtTagT, data: bus.WrtDataT, name: bus.WrtNameT};
  endfunction

  task automatic new_entry(input int s);
    cur[s] = mk(s, seq, 5'(16'd1 + seq % 16'd31), 5'(seq));
    seq++;
  endtask

  task automatic apply();
    bus.flush     = flush_v;
    bus.alu_valid = offer[0]; bus.alu_tag = cur[0].tag; bus.alu_data = cur[0].data; bus.alu_name = cur[0].name;
    bus.ls_valid  = offer[1]; bus.ls_tag  = cur[1].tag; bus.ls_data  = cur[1].data; bus.ls_name  = cur[1].name;
    bus.br_valid  = offer[2]; bus.br_tag  = cur[2].tag; bus.br_data  = cur[2].data; bus.br_name  = cur[2].name;
  endtask

  // Pop the oldest expected entry of source s and compare with a broadcast.
  task automatic take(input logic [1:0] s, input cdb_entry_t obs, input string tag);
    cdb_entry_t e;
    logic ok;
    ok = (s < 2'd3) && (sb[s].size() > 0);
    chk({tag, "_has_entry"}, 64'(ok), 64'(1));
    if (ok) begin
      e = sb[s].pop_front();
      chk({tag, "_entry"}, 64'(obs), 64'(e));
    end
  endtask

  // One clock: drive, check ready, clock, check broadcasts against scoreboard.
  task automatic step();
    logic [2:0] rdy;
    logic [1:0] so, st;
    logic       exp_busy;
    so = 2'd0;
    st = 2'd0;
    apply();
    rdy = {bus.br_ready, bus.ls_ready, bus.alu_ready};
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("ready%0d", s), 64'(rdy[s]), 64'(sb[s].size() < 2));
      had[s] = (sb[s].size() != 0);
      acc[s] = offer[s] & rdy[s] & ~flush_v;
    end
    if (!rdy[1]) saw_ls_full = 1'b1;
    @(posedge clk);
    #1;
    got = '0;
    if (flush_v) begin
      chk("flush_enO", 64'(bus.enWrtO), 64'(0));
      chk("flush_enT", 64'(bus.enWrtT), 64'(0));
      for (int s = 0; s < 3; s++) sb[s].delete();
    end else begin
      if (bus.enWrtT) chk("O_idle_while_T", 64'(bus.enWrtO), 64'(1));
      if (bus.enWrtO) begin
        so = bus.WrtDataO[31:30];
        take(so, obs_o(), "bcastO");
        if (so < 2'd3) got[so] = 1'b1;
      end else begin
        chk("idleO", 64'(obs_o()), 64'(CDB_IDLE));
      end
      if (bus.enWrtT) begin
        st = bus.WrtDataT[31:30];
        take(st, obs_t(), "bcastT");
        if (st < 2'd3) got[st] = 1'b1;
      end else begin
        chk("idleT", 64'(obs_t()), 64'(CDB_IDLE));
      end
      if (bus.enWrtO && bus.enWrtT) chk("same_src", 64'(so == st), 64'(0));
    end
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) sb[s].push_back(cur[s]);
      if (had[s] && !flush_v) begin
        wait_cnt[s] = got[s] ? 0 : wait_cnt[s] + 1;
        chk($sformatf("starve%0d", s), 64'(wait_cnt[s] <= 2), 64'(1));
      end else begin
        wait_cnt[s] = 0;
      end
    end
    exp_busy = (sb[0].size() != 0) || (sb[1].size() != 0) || (sb[2].size() != 0) ||
               bus.enWrtO || bus.enWrtT;
    chk("busy", 64'(bus.busy), 64'(exp_busy));
  endtask

  task automatic rst_chk(input string p);
    chk({p, "_enO"},   64'(bus.enWrtO),   64'(0));
    chk({p, "_enT"},   64'(bus.enWrtT),   64'(0));
    chk({p, "_tagO"},  64'(bus.WrtTagO),  64'(TAG_FREE));
    chk({p, "_tagT"},  64'(bus.WrtTagT),  64'(TAG_FREE));
    chk({p, "_dataO"}, 64'(bus.WrtDataO), 64'(0));
    chk({p, "_dataT"}, 64'(bus.WrtDataT), 64'(0));
    chk({p, "_nameO"}, 64'(bus.WrtNameO), 64'(0));
    chk({p, "_nameT"}, 64'(bus.WrtNameT), 64'(0));
    chk({p, "_ready"}, 64'({bus.br_ready, bus.ls_ready, bus.alu_ready}), 64'(3'b111));
    chk({p, "_busy"},  64'(bus.busy),     64'(0));
  endtask

  task automatic drain(input string p);
    for (int c = 0; c < 20; c++) begin
      if (!bus.busy && sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
      step();
    end
    chk({p, "_busy"}, 64'(bus.busy), 64'(0));
    chk({p, "_left"}, 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cdb_entry_t a0, l0, b0, n0;
    rst = 1'b0;
    offer = '0;
    acc = '0;
    flush_v = 1'b0;
    seq = 16'd1;
    saw_ls_full = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cur[s] = mk(s, 16'd0, 5'd0, 5'd0);
      wait_cnt[s] = 0;
    end
    apply();
    #12;
    rst_chk("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Three simultaneous pushes with rr_ptr = 0.
    new_entry(0); new_entry(1); new_entry(2);
    a0 = cur[0]; l0 = cur[1]; b0 = cur[2];
    offer = 3'b111;
    step();
    chk("t3_first_edge_enO", 64'(bus.enWrtO), 64'(0));
    offer = 3'b000;
    step();
    chk("t3_O_alu", 64'(obs_o()), 64'(a0));
    chk("t3_T_ls",  64'(obs_t()), 64'(l0));
    step();
    chk("t3_O_br",  64'(obs_o()), 64'(b0));
    chk("t3_T_idle_en",  64'(bus.enWrtT), 64'(0));
    chk("t3_T_idle_tag", 64'(bus.WrtTagT), 64'(TAG_FREE));
    step();
    chk("t3_idle", 64'(bus.enWrtO), 64'(0));

    // Single ALU push; rr_ptr is back at 0 so the alu entry must land on O.
    cur[0] = '{tag: 5'd5, data: 32'h0000_1234, name: 5'd3};
    offer = 3'b001;
    step();
    chk("t1_latency", 64'(bus.enWrtO), 64'(0));
    offer = 3'b000;
    step();
    chk("t1_enO",   64'(bus.enWrtO),   64'(1));
    chk("t1_tagO",  64'(bus.WrtTagO),  64'(5));
    chk("t1_dataO", 64'(bus.WrtDataO), 64'(32'h1234));
    chk("t1_nameO", 64'(bus.WrtNameO), 64'(3));
    chk("t1_enT",   64'(bus.enWrtT),   64'(0));
    step();

    // All sources saturate; ls must back-pressure and keep order.
    new_entry(0); new_entry(1); new_entry(2);
    offer = 3'b111;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int s = 0; s < 3; s++) if (acc[s]) new_entry(s);
    end
    chk("sat_ls_ready_dropped", 64'(saw_ls_full), 64'(1));
    offer = 3'b000;
    drain("sat_drain");

    // Flush with two entries queued and a push in the same cycle.
    new_entry(0); new_entry(1);
    offer = 3'b011;
    step();
    new_entry(2);
    offer = 3'b100;
    flush_v = 1'b1;
    step();
    chk("flush_busy", 64'(bus.busy), 64'(0));
    chk("flush_br_ready", 64'(bus.br_ready), 64'(1));
    flush_v = 1'b0;
    offer = 3'b000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("post_flush_enO%0d", c), 64'(bus.enWrtO), 64'(0));
    end

    // Asynchronous reset between edges while queues hold data.
    new_entry(0); new_entry(1); new_entry(2);
    offer = 3'b111;
    step();
    for (int s = 0; s < 3; s++) if (acc[s]) new_entry(s);
    step();
    chk("pre_rst_enO", 64'(bus.enWrtO), 64'(1));
    offer = 3'b000;
    apply();
    #2;
    rst = 1'b0;
    #1;
    rst_chk("async_rst");
    for (int s = 0; s < 3; s++) begin
      sb[s].delete();
      wait_cnt[s] = 0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    chk("post_rst_enO", 64'(bus.enWrtO), 64'(0));
    new_entry(0);
    n0 = cur[0];
    offer = 3'b001;
    step();
    offer = 3'b000;
    step();
    chk("post_rst_O", 64'(obs_o()), 64'(n0));

    // Random valid/flush traffic; sources hold unaccepted results.
    acc = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!offer[s] || acc[s]) begin
          if ($urandom_range(99) < 60) begin
            new_entry(s);
            offer[s] = 1'b1;
          end else begin
            offer[s] = 1'b0;
          end
        end
      end
      flush_v = ($urandom_range(99) < 3);
      step();
    end
    flush_v = 1'b0;
    offer = 3'b000;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
